// File: rtl/ab_seq_pkg.sv
// Shared types and constants for the a-then-b pair sequence generator.
package ab_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEND_A = 3'd1,
      SEND_B = 3'd2,
      GAP    = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int MIN_GAP = 1;

endpackage

// File: rtl/ab_sequence_generator.sv
// Emits a burst of a-then-b pulse pairs separated by idle gap cycles, then a one-cycle done.
// Optional loopback checker on q_in/err is enabled by defining LOOPBACK_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for start; count/gap captured on acceptance
// SEND_A | a high for one cycle
// SEND_B | b high for one cycle; pair counter decrements
// GAP    | idle cycles between pairs (at least MIN_GAP)
// DONE   | one-cycle done pulse, start ignored here
module ab_sequence_generator
   import ab_seq_pkg::*;
#(
   parameter int CNT_W = 4,
   parameter int GAP_W = 3
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic [GAP_W-1:0] gap,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done
`ifdef LOOPBACK_CHECK_EN
   ,
   input  logic             q_in,
   output logic             err
`endif
);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] pair_cnt;
   logic [GAP_W-1:0] gap_reg;
   logic [GAP_W-1:0] gap_cnt;
   logic             accept;
   logic             last_pair;
   logic             gap_done;
   logic [GAP_W-1:0] gap_eff;

   assign accept    = (state == IDLE) && start;
   assign last_pair = (pair_cnt == CNT_W'(1));
   assign gap_done  = (gap_cnt == GAP_W'(1));
   assign gap_eff   = (gap < GAP_W'(MIN_GAP)) ? GAP_W'(MIN_GAP) : gap;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (count == '0) ? DONE : SEND_A;
            end
         end
         SEND_A:  next_state = SEND_B;
         SEND_B:  next_state = last_pair ? DONE : GAP;
         GAP: begin
            if (gap_done) begin
               next_state = SEND_A;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Counters never wrap: decrements are guarded by a nonzero check.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         pair_cnt <= '0;
         gap_reg  <= '0;
         gap_cnt  <= '0;
      end else begin
         if (accept) begin
            pair_cnt <= count;
            gap_reg  <= gap_eff;
         end else if (state == SEND_B && pair_cnt != '0) begin
            pair_cnt <= pair_cnt - CNT_W'(1);
         end

         if (state == SEND_B) begin
            gap_cnt <= gap_reg;
         end else if (state == GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
         end
      end
   end

   assign a    = (state == SEND_A);
   assign b    = (state == SEND_B);
   assign done = (state == DONE);
   assign busy = (state != IDLE);

`ifdef LOOPBACK_CHECK_EN
   logic after_b;
   logic err_q;
   logic violation;

   // q_in must be high exactly in the cycle following each b, and low in every other busy cycle.
   assign violation = (state != IDLE) && (after_b ? !q_in : q_in);
   assign err       = err_q | violation;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         after_b <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         after_b <= (state == SEND_B);
         if (accept) begin
            err_q <= 1'b0;
         end else if (violation) begin
            err_q <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ab_sequence_generator.sv
// Directed self-checking bench for ab_sequence_generator; per-cycle traces compared to hand-computed vectors.
`timescale 1ns/1ps
module tb_ab_sequence_generator;

   logic       CLK = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] count = '0;
   logic [2:0] gap = '0;
   logic       a;
   logic       b;
   logic       busy;
   logic       done;
   int         n_checks = 0;
   int         n_fail = 0;

`ifdef LOOPBACK_CHECK_EN
   logic q_in;
   logic err;
   logic q_ref = 1'b0;
   logic lb_zero = 1'b0;
   always @(posedge CLK) q_ref <= b;
   assign q_in = lb_zero ? 1'b0 : q_ref;
`endif

   always #5 CLK = ~CLK;

   ab_sequence_generator #(.CNT_W(4), .GAP_W(3)) dut (
      .CLK   (CLK),
      .reset (reset),
      .start (start),
      .count (count),
      .gap   (gap),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done)
`ifdef LOOPBACK_CHECK_EN
      ,
      .q_in  (q_in),
      .err   (err)
`endif
   );

   // Start in cycle 0, then record outputs of cycles 1..ncyc at the falling edge.
   task automatic run_burst(input logic [3:0] cnt, input logic [2:0] gp, input int ncyc,
                            output logic [63:0] a_tr, output logic [63:0] b_tr,
                            output logic [63:0] busy_tr, output logic [63:0] done_tr);
      a_tr = '0; b_tr = '0; busy_tr = '0; done_tr = '0;
      @(negedge CLK);
      count = cnt; gap = gp; start = 1'b1;
      @(negedge CLK);
      start = 1'b0; count = ~cnt; gap = ~gp;
      for (int i = 1; i <= ncyc; i++) begin
         a_tr[i] = a; b_tr[i] = b; busy_tr[i] = busy; done_tr[i] = done;
         @(negedge CLK);
      end
   endtask

   task automatic check_traces(input string name,
                               input logic [63:0] a_tr, input logic [63:0] b_tr,
                               input logic [63:0] busy_tr, input logic [63:0] done_tr,
                               input logic [63:0] a_ex, input logic [63:0] b_ex,
                               input logic [63:0] busy_ex, input logic [63:0] done_ex);
      n_checks += 4;
      if (a_tr !== a_ex) begin
         n_fail++; $display("FAIL %s a trace: got %h expected %h", name, a_tr, a_ex);
      end
      if (b_tr !== b_ex) begin
         n_fail++; $display("FAIL %s b trace: got %h expected %h", name, b_tr, b_ex);
      end
      if (busy_tr !== busy_ex) begin
         n_fail++; $display("FAIL %s busy trace: got %h expected %h", name, busy_tr, busy_ex);
      end
      if (done_tr !== done_ex) begin
         n_fail++; $display("FAIL %s done trace: got %h expected %h", name, done_tr, done_ex);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      n_checks++;
      if ({a, b, busy, done} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_outputs: got %b expected 0000", {a, b, busy, done});
      end
      repeat (2) @(negedge CLK);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [63:0] at, bt, yt, dt;
      run_burst(4'd2, 3'd2, 10, at, bt, yt, dt);
      check_traces("basic_c2_g2", at, bt, yt, dt, 64'h22, 64'h44, 64'hFE, 64'h80);
   endtask

   task automatic test_count_zero();
      logic [63:0] at, bt, yt, dt;
      run_burst(4'd0, 3'd3, 6, at, bt, yt, dt);
      check_traces("count_zero", at, bt, yt, dt, 64'h0, 64'h0, 64'h2, 64'h2);
   endtask

   task automatic test_gap_zero();
      logic [63:0] at, bt, yt, dt;
      run_burst(4'd3, 3'd0, 12, at, bt, yt, dt);
      check_traces("gap_zero_c3", at, bt, yt, dt, 64'h92, 64'h124, 64'h3FE, 64'h200);
   endtask

   task automatic test_single_pair_max_gap();
      logic [63:0] at, bt, yt, dt;
      run_burst(4'd1, 3'd7, 8, at, bt, yt, dt);
      check_traces("single_pair_g7", at, bt, yt, dt, 64'h2, 64'h4, 64'hE, 64'h8);
   endtask

   task automatic test_max_count();
      logic [63:0] at, bt, yt, dt;
      run_burst(4'd15, 3'd0, 50, at, bt, yt, dt);
      n_checks += 3;
      if ($countones(at) !== 15) begin
         n_fail++; $display("FAIL max_count a pulses: got %0d expected 15", $countones(at));
      end
      if ($countones(bt) !== 15) begin
         n_fail++; $display("FAIL max_count b pulses: got %0d expected 15", $countones(bt));
      end
      if (dt !== (64'h1 << 45)) begin
         n_fail++; $display("FAIL max_count done trace: got %h expected %h", dt, 64'h1 << 45);
      end
   endtask

   task automatic test_start_in_done();
      @(negedge CLK);
      count = 4'd0; gap = 3'd1; start = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL start_in_done done cycle1: got %b expected 1", done);
      end
      @(negedge CLK);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL start_in_done busy cycle2: got %b expected 0", busy);
      end
      @(negedge CLK);
      start = 1'b0;
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL start_in_done restart done: got %b expected 1", done);
      end
      repeat (3) @(negedge CLK);
   endtask

   task automatic test_hold_start();
      logic [63:0] at, bt, yt, dt;
      at = '0; bt = '0; yt = '0; dt = '0;
      @(negedge CLK);
      count = 4'd2; gap = 3'd1; start = 1'b1;
      @(negedge CLK);
      count = 4'd5;
      for (int i = 1; i <= 8; i++) begin
         at[i] = a; bt[i] = b; yt[i] = busy; dt[i] = done;
         @(negedge CLK);
      end
      start = 1'b0;
      check_traces("hold_start", at, bt, yt, dt, 64'h112, 64'h24, 64'h17E, 64'h40);
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
   endtask

   task automatic test_reset_mid_burst();
      logic [63:0] at, bt, yt, dt;
      logic        saw_done;
      @(negedge CLK);
      count = 4'd4; gap = 3'd1; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (4) @(negedge CLK);
      n_checks++;
      if (b !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid pre b: got %b expected 1", b);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({a, b, busy, done} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_mid outputs: got %b expected 0000", {a, b, busy, done});
      end
      saw_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         if (i == 1) reset = 1'b0;
         saw_done = saw_done | done;
      end
      n_checks++;
      if (saw_done !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid done pulse: got %b expected 0", saw_done);
      end
      run_burst(4'd4, 3'd1, 14, at, bt, yt, dt);
      check_traces("after_reset_c4", at, bt, yt, dt, 64'h492, 64'h924, 64'h1FFE, 64'h1000);
   endtask

`ifdef LOOPBACK_CHECK_EN
   task automatic test_loopback();
      logic [63:0] et;
      logic        any_err;
      lb_zero = 1'b0;
      any_err = 1'b0;
      @(negedge CLK);
      count = 4'd2; gap = 3'd2; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         any_err = any_err | err;
         @(negedge CLK);
      end
      n_checks++;
      if (any_err !== 1'b0) begin
         n_fail++; $display("FAIL loopback_ref err: got %b expected 0", any_err);
      end
      lb_zero = 1'b1;
      et = '0;
      @(negedge CLK);
      count = 4'd2; gap = 3'd2; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         et[i] = err;
         @(negedge CLK);
      end
      n_checks++;
      if (et[10:1] !== 10'b11_1111_1100) begin
         n_fail++; $display("FAIL loopback_zero err trace: got %b expected 1111111100", et[10:1]);
      end
      lb_zero = 1'b0;
      count = 4'd1; gap = 3'd1; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++; $display("FAIL loopback_clear err: got %b expected 0", err);
      end
      repeat (4) @(negedge CLK);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_count_zero();
      test_gap_zero();
      test_single_pair_max_gap();
      test_max_count();
      test_start_in_done();
      test_hold_start();
      test_reset_mid_burst();
`ifdef LOOPBACK_CHECK_EN
      test_loopback();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ab_sequence_generator.md
AB_SEQUENCE_GENERATOR -- requirements
Module: ab_sequence_generator

Interface
REQ-001 Parameter CNT_W SHALL default to 4 and sets the width of the pair count.
REQ-002 Parameter GAP_W SHALL default to 3 and sets the width of the inter-pair gap.
REQ-003 Port CLK SHALL be a 1-bit input clock; all state updates occur on its rising edge.
REQ-004 Port reset SHALL be a 1-bit input; reset is asynchronous and active-high.
REQ-005 Port start SHALL be a 1-bit input that requests one burst of a-then-b pairs.
REQ-006 Port count SHALL be a CNT_W-bit input giving the number of pairs to send.
REQ-007 Port gap SHALL be a GAP_W-bit input giving the idle cycles between pairs.
REQ-008 Port a SHALL be a 1-bit output, driven high for one cycle per pair.
REQ-009 Port b SHALL be a 1-bit output, driven high in the cycle immediately after each a.
REQ-010 Port busy SHALL be a 1-bit output, high whenever the FSM is not in IDLE.
REQ-011 Port done SHALL be a 1-bit output giving a one-cycle pulse at burst end.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, SEND_A, SEND_B, GAP and DONE.
REQ-013 start SHALL be accepted only when sampled high in IDLE; start in any other state SHALL be ignored.
REQ-014 count and gap SHALL be captured into internal registers on acceptance; later changes to them SHALL have no effect on the burst in progress.
REQ-015 On acceptance with count=0, the FSM SHALL go IDLE->DONE, emitting no a/b pulses.
REQ-016 On acceptance with count>0, the FSM SHALL go IDLE->SEND_A, so a is high in the first cycle after the start cycle.
REQ-017 SEND_A SHALL always be followed by SEND_B.
REQ-018 From SEND_B, the FSM SHALL go to DONE if this was the last pair, otherwise to GAP.
REQ-019 The effective gap SHALL be max(gap,1) cycles, so a downstream a-then-b detector re-arms; gap=0 SHALL behave as gap=1.
REQ-020 When the effective gap cycles have elapsed, GAP SHALL go to SEND_A.
REQ-021 DONE SHALL last exactly one cycle and then go to IDLE.
REQ-022 Outputs SHALL be Moore-decoded from the state:
  - a=1 only in SEND_A;
  - b=1 only in SEND_B;
  - done=1 only in DONE;
  - busy=1 in every state except IDLE.
REQ-023 A start sampled high in the DONE cycle SHALL be ignored; the earliest accepted restart is in the cycle after DONE.
REQ-024 Pair and gap counters SHALL be down-counters of width CNT_W and GAP_W respectively; neither SHALL wrap below zero.

Reset
REQ-025 When reset is asserted, the FSM SHALL enter IDLE immediately.
REQ-026 During reset, a, b, busy and done SHALL all be 0 and all counters SHALL be 0.
REQ-027 Reset asserted mid-burst SHALL abort the burst with no done pulse.
REQ-028 After reset is released, the first accepted start SHALL behave exactly as from power-up.

Configuration
REQ-029 With LOOPBACK_CHECK_EN defined, the block SHALL have a 1-bit input q_in and a 1-bit sticky output err.
REQ-030 With LOOPBACK_CHECK_EN defined, err SHALL be set in either of these cases:
  - q_in is 0 in the cycle immediately after any SEND_B (the first GAP cycle or DONE);
  - q_in is 1 in any other non-IDLE cycle.
REQ-031 With LOOPBACK_CHECK_EN defined, err SHALL be cleared by reset and by start acceptance.
REQ-032 Without LOOPBACK_CHECK_EN, neither q_in nor err SHALL exist and no check logic SHALL be present.

Structure
REQ-033 A shared package ab_seq_pkg SHALL hold the state enum (logic[2:0]: IDLE, SEND_A, SEND_B, GAP, DONE) and the MIN_GAP=1 constant.
REQ-034 No sub-module SHALL be used; the counters and FSM SHALL reside in ab_sequence_generator.

Verification
REQ-035 Start at cycle 0 with count=2, gap=2 -> a high in cycles 1 and 5; b high in cycles 2 and 6; done in cycle 7; busy high in cycles 1-7.
REQ-036 Start with count=0 -> done high in the next cycle; a and b stay 0 throughout; busy high for that one cycle only.
REQ-037 count=3, gap=0 -> a/b pulse pairs separated by exactly 1 idle cycle (a in cycles 1, 4, 7); done in cycle 9.
REQ-038 start held high for the whole burst, with count changed mid-burst -> the original count is honoured; exactly one burst runs before the cycle after DONE.
REQ-039 Reset asserted in SEND_B of pair 2 of 4 -> all outputs 0 immediately, no done pulse; a fresh start runs a full 4-pair burst.
REQ-040 LOOPBACK_CHECK_EN defined with q_in driven by a reference detector -> err stays 0. With q_in tied to 0 -> err is set in the cycle after the first b and holds until the next start.
